pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use and multi-cycle
// mul/div stalls, branch flushes, mul/div watchdog and a stall-cycle counter.
module pipe_hazard_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic [1:0]  ResultSrcE,
    input  logic        PCSrcE,
    input  logic        MulDivStartE,
    input  logic        MulDivDoneE,
    input  logic        CntClear,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushM,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        MdBusy,
    output logic        MdTimeout,
    output logic [15:0] StallCount
);

    typedef enum logic {ST_RUN = 1'b0, ST_BUSY = 1'b1} md_state_t;

    md_state_t   r_state;
    md_state_t   w_state_nxt;
    logic [5:0]  r_md_cyc;
    logic        r_md_timeout;
    logic [15:0] r_stall_count;
    logic        w_lw_stall;
    logic        w_md_stall;
    logic        w_cyc_max;

    // Memory stage wins over Writeback because it holds the younger result.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic       wr_m, input logic [4:0] rd_m,
                                           input logic       wr_w, input logic [4:0] rd_w);
        logic [1:0] sel;
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = 2'b10;
        end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Hazard detection terms.
    always_comb begin
        w_cyc_max  = (r_md_cyc == 6'd63);
        w_lw_stall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                     ((Rs1D == RdE) || (Rs2D == RdE));
        w_md_stall = ((r_state == ST_RUN)  && MulDivStartE && !MulDivDoneE) ||
                     ((r_state == ST_BUSY) && !MulDivDoneE && !w_cyc_max);
    end

    // Mul/div FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (MulDivStartE && !MulDivDoneE) begin
                    w_state_nxt = ST_BUSY;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_BUSY: begin
                if (MulDivDoneE || w_cyc_max) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_BUSY;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // Stall/flush/forward outputs; a multi-cycle stall masks branch and load-use.
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (reset) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushM = 1'b1;
        end else if (w_md_stall) begin
            StallF    = 1'b1;
            StallD    = 1'b1;
            StallE    = 1'b1;
            FlushM    = 1'b1;
            ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
            ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
        end else begin
            StallF    = w_lw_stall;
            StallD    = w_lw_stall;
            FlushD    = PCSrcE;
            FlushE    = w_lw_stall | PCSrcE;
            ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
            ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
        end
    end

    // FSM state, busy-cycle counter and watchdog pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_RUN;
            r_md_cyc     <= 6'd0;
            r_md_timeout <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_md_cyc     <= ((r_state == ST_BUSY) && (w_state_nxt == ST_BUSY)) ?
                            (r_md_cyc + 6'd1) : 6'd0;
            r_md_timeout <= (r_state == ST_BUSY) && !MulDivDoneE && w_cyc_max;
        end
    end

    // Saturating stall-cycle counter; clear beats increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= 16'd0;
        end else if (CntClear) begin
            r_stall_count <= 16'd0;
        end else if (StallF && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end else begin
            r_stall_count <= r_stall_count;
        end
    end

    assign MdBusy     = (r_state == ST_BUSY);
    assign MdTimeout  = r_md_timeout;
    assign StallCount = r_stall_count;

endmodule
